hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the decode stage and issues stall, flush and freeze controls to the IF, ID, EX and MEM stage registers.
- Keeps a per-register load scoreboard to detect load-use hazards; ALU results are forwarded, loads are not.
- Inserts redirect bubbles after taken branches and jumps resolved in EX, and freezes the whole pipe while data memory is not ready.

Parameters:
- XADDR, 5, register address width (32 architectural registers).
- FLUSH_CYCLES, 2, bubble cycles inserted after a redirect (1..7).

Ports:
- i_clk  in  1  CPU clock.
- i_rst  in  1  asynchronous active-high reset.
- i_id_valid  in  1  ID holds a valid instruction.
- i_id_rs1_addr  in  XADDR  ID source register 1.
- i_id_rs2_addr  in  XADDR  ID source register 2.
- i_id_uses_rs1  in  1  ID instruction reads rs1.
- i_id_uses_rs2  in  1  ID instruction reads rs2.
- i_id_rd_addr  in  XADDR  ID destination register.
- i_id_is_load  in  1  ID instruction is a load (L_OP).
- i_wb_load_valid  in  1  a load result is written back this cycle.
- i_wb_rd_addr  in  XADDR  writeback destination.
- i_ex_redirect  in  1  taken branch or jump resolved in EX (1-cycle pulse).
- i_mem_req  in  1  MEM stage holds a load or store.
- i_mem_ready  in  1  data memory completes this cycle.
- o_stall_if  out  1  hold PC and IF/ID register.
- o_stall_id  out  1  hold ID (no issue).
- o_bubble_ex  out  1  load NOP into ID/EX.
- o_flush_id  out  1  squash IF/ID contents.
- o_freeze  out  1  hold every stage register (EX, MEM, WB included).
- o_state  out  2  FSM state, for debug.

Behaviour:
- Reset (i_rst asynchronous, active-high): state RUN, scoreboard all zero, flush counter 0, redirect latch 0. All control outputs 0, o_state 0.
- FSM states: RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3. Outputs are combinational from state and inputs; state, scoreboard and counter are registered.
- Priority each cycle: memwait > redirect > load-use > run.
- memwait = i_mem_req && !i_mem_ready.
  - Drives o_freeze=1, o_stall_if=1, o_stall_id=1; no other outputs.
  - Next state is MEMWAIT.
  - An i_ex_redirect seen while frozen sets a redirect latch.
- Redirect (i_ex_redirect, or the latch when not frozen):
  - Drives o_flush_id=1 and o_bubble_ex=1 that cycle.
  - Latch clears; counter loads FLUSH_CYCLES-1; next state is FLUSH.
  - In FLUSH, o_flush_id=1 and o_bubble_ex=1 every cycle. Counter decrements; state returns to RUN when it reaches 0.
  - A new redirect in FLUSH reloads the counter.
  - With FLUSH_CYCLES=1, the next state is RUN directly.
- Load-use hazard: i_id_valid && ((i_id_uses_rs1 && rs1!=0 && sb[rs1]) || (i_id_uses_rs2 && rs2!=0 && sb[rs2])).
  - Drives o_stall_if=1, o_stall_id=1, o_bubble_ex=1; state is LDSTALL.
  - State re-evaluates every cycle and returns to RUN once the hazard clears.
  - There is no WB-to-ID bypass. A register being written back in cycle t still counts as pending in t; issue happens at t+1.
- Issue = i_id_valid && !o_stall_id && !o_flush_id && !o_freeze.
  - On issue with i_id_is_load and rd!=0, set sb[rd].
- On i_wb_load_valid with rd!=0 and !o_freeze, clear sb[rd].
- Set and clear of the same register in the same cycle: set wins.
- sb[0] is always 0.
- A redirect never clears scoreboard bits: older loads are still in flight.
- Reset mid-stall, mid-flush or mid-memwait returns everything to the reset state immediately.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined: extra outputs o_stall_cnt[31:0], o_flush_cnt[31:0], o_memwait_cnt[31:0]. These are wrapping counters of cycles spent in LDSTALL, FLUSH (including the redirect cycle) and MEMWAIT. They reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add to header.vh: HZ_RUN, HZ_LDSTALL, HZ_FLUSH, HZ_MEMWAIT state encodings, and the scoreboard width (1<<XADDR).
- Reuse the existing XADDR and L_OP constants.
- One sub-module: load_scoreboard. It holds the 32-bit pending vector with set/clear/query ports, two query addresses and two hit outputs.

Test Plan:
- Issue load to x5, next ID reads x5 (uses_rs1) → 1-cycle gap before WB. Expect o_stall_id=1, o_bubble_ex=1, o_state=1 for each cycle through the WB cycle, then issue the cycle after.
- Load to x0, then read x0 → no stall; sb stays all zero.
- i_ex_redirect pulse with FLUSH_CYCLES=2 → o_flush_id=1 for exactly 2 cycles, then o_state=0.
- i_mem_req=1, i_mem_ready=0 for 3 cycles, with i_ex_redirect on the 2nd cycle → o_freeze=1 for 3 cycles, then 2 flush cycles start on the first unfrozen cycle.
- Same-cycle WB clear of x7 and issue of a new load to x7 → sb[7] remains 1; a dependent read of x7 stalls.
- Assert i_rst asynchronously during FLUSH → all outputs 0 before the next i_clk edge; sb cleared.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants for the pipeline hazard controller
//
// Purpose : register-address width, scoreboard width, load opcode and the
//           FSM state encodings used by hazard_ctrl and load_scoreboard.
// Ports   : none (package).
package hazard_ctrl_pkg;

  localparam int XADDR = 5;
  localparam int SB_W  = 1 << XADDR;

  localparam logic [6:0] L_OP = 7'b0000011;

  localparam logic [1:0] HZ_RUN     = 2'd0;
  localparam logic [1:0] HZ_LDSTALL = 2'd1;
  localparam logic [1:0] HZ_FLUSH   = 2'd2;
  localparam logic [1:0] HZ_MEMWAIT = 2'd3;

endpackage

// File: rtl/hazard_ctrl_load_scoreboard.sv
// rtl/hazard_ctrl_load_scoreboard.sv - per-register pending-load bit vector
//
// Purpose : one pending bit per architectural register. A bit is set when a
//           load to that register issues and cleared when its result is
//           written back. Entry 0 is hard-wired to 0.
// Ports   : i_clk, i_rst          clock, async active-high reset
//           i_set_en, i_set_addr  mark register pending
//           i_clr_en, i_clr_addr  mark register written back
//           i_q1_addr/o_q1_hit    query port 1 (registered view)
//           i_q2_addr/o_q2_hit    query port 2 (registered view)
module load_scoreboard #(
  parameter int XADDR = hazard_ctrl_pkg::XADDR
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_set_en,
  input  logic [XADDR-1:0] i_set_addr,
  input  logic             i_clr_en,
  input  logic [XADDR-1:0] i_clr_addr,
  input  logic [XADDR-1:0] i_q1_addr,
  input  logic [XADDR-1:0] i_q2_addr,
  output logic             o_q1_hit,
  output logic             o_q2_hit
);

  localparam int SB_W = 1 << XADDR;

  logic [SB_W-1:0] pend_q;
  logic [SB_W-1:0] pend_d;

  // Queries see only the registered vector: a register written back this
  // cycle is still pending until the next one (no WB-to-ID bypass).
  assign o_q1_hit = (i_q1_addr != '0) && pend_q[i_q1_addr];
  assign o_q2_hit = (i_q2_addr != '0) && pend_q[i_q2_addr];

  always_comb begin
    pend_d = pend_q;
    if (i_clr_en && (i_clr_addr != '0)) begin
      pend_d[i_clr_addr] = 1'b0;
    end
    // Set is applied after clear so a new load to the same register wins.
    if (i_set_en && (i_set_addr != '0)) begin
      pend_d[i_set_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/freeze sequencing for the 5-stage RV32I core
//
// Purpose : detects load-use hazards via a load scoreboard, inserts redirect
//           bubbles after EX-resolved branches/jumps and freezes the pipe
//           while data memory is busy. Priority: memwait > redirect >
//           load-use > run.
// Ports   : i_clk, i_rst                         clock, async active-high reset
//           i_id_*                               decode-stage instruction info
//           i_wb_load_valid, i_wb_rd_addr        load writeback
//           i_ex_redirect                        taken branch/jump pulse
//           i_mem_req, i_mem_ready               data memory handshake
//           o_stall_if, o_stall_id, o_bubble_ex,
//           o_flush_id, o_freeze                 stage-register controls
//           o_state                              current FSM state (debug)
// Config  : HAZARD_PERF_EN adds o_stall_cnt, o_flush_cnt, o_memwait_cnt.
module hazard_ctrl #(
  parameter int XADDR        = hazard_ctrl_pkg::XADDR,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [XADDR-1:0] i_id_rd_addr,
  input  logic             i_id_is_load,
  input  logic             i_wb_load_valid,
  input  logic [XADDR-1:0] i_wb_rd_addr,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic             o_freeze,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      o_stall_cnt,
  output logic [31:0]      o_flush_cnt,
  output logic [31:0]      o_memwait_cnt,
`endif
  output logic [1:0]       o_state
);

  import hazard_ctrl_pkg::*;

  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state_q, state_d, cur_state;
  logic [2:0] cnt_q, cnt_d;
  logic       latch_q, latch_d;

  logic stall_if, stall_id, bubble_ex, flush_id, freeze;
  logic memwait, redirect, flush_pend, load_use, issue;
  logic hit1, hit2;

  assign memwait  = i_mem_req && !i_mem_ready;
  assign redirect = i_ex_redirect || latch_q;
  // A flush interrupted by a memory wait resumes once the pipe unfreezes.
  assign flush_pend = ((state_q == HZ_FLUSH) || (state_q == HZ_MEMWAIT)) && (cnt_q != 3'd0);
  assign load_use   = i_id_valid && ((i_id_uses_rs1 && hit1) || (i_id_uses_rs2 && hit2));

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    cur_state = HZ_RUN;
    state_d   = HZ_RUN;
    cnt_d     = cnt_q;
    latch_d   = latch_q;
    if (memwait) begin
      freeze    = 1'b1;
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      cur_state = HZ_MEMWAIT;
      state_d   = HZ_MEMWAIT;
      latch_d   = latch_q | i_ex_redirect;
    end else if (redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      cur_state = HZ_FLUSH;
      latch_d   = 1'b0;
      cnt_d     = CNT_RELOAD;
      state_d   = (FLUSH_CYCLES == 1) ? HZ_RUN : HZ_FLUSH;
    end else if (flush_pend) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      cur_state = HZ_FLUSH;
      cnt_d     = cnt_q - 3'd1;
      state_d   = (cnt_q == 3'd1) ? HZ_RUN : HZ_FLUSH;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      cur_state = HZ_LDSTALL;
      state_d   = HZ_LDSTALL;
    end
  end

  assign issue = i_id_valid && !stall_id && !flush_id && !freeze;

  // Outputs are forced low while reset is asserted so the pipe sees a clean
  // idle controller before the first clock edge.
  assign o_stall_if  = stall_if  && !i_rst;
  assign o_stall_id  = stall_id  && !i_rst;
  assign o_bubble_ex = bubble_ex && !i_rst;
  assign o_flush_id  = flush_id  && !i_rst;
  assign o_freeze    = freeze    && !i_rst;
  assign o_state     = i_rst ? HZ_RUN : cur_state;

  load_scoreboard #(.XADDR(XADDR)) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set_en   (issue && i_id_is_load),
    .i_set_addr (i_id_rd_addr),
    .i_clr_en   (i_wb_load_valid && !freeze),
    .i_clr_addr (i_wb_rd_addr),
    .i_q1_addr  (i_id_rs1_addr),
    .i_q2_addr  (i_id_rs2_addr),
    .o_q1_hit   (hit1),
    .o_q2_hit   (hit2)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= 3'd0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (cur_state == HZ_LDSTALL) stall_cnt_q   <= stall_cnt_q + 32'd1;
      if (cur_state == HZ_FLUSH)   flush_cnt_q   <= flush_cnt_q + 32'd1;
      if (cur_state == HZ_MEMWAIT) memwait_cnt_q <= memwait_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt   = stall_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;
  assign o_memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, uses_rs1, uses_rs2, is_load;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic       wb_valid, redir, mem_req, mem_ready;
  logic       stall_if, stall_id, bubble_ex, flush_id, freeze;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // {freeze, stall_if, stall_id, bubble_ex, flush_id, state}
  localparam logic [6:0] E_RUN  = 7'b0000000;
  localparam logic [6:0] E_LDS  = 7'b0111001;
  localparam logic [6:0] E_FLS  = 7'b0001110;
  localparam logic [6:0] E_MEMW = 7'b1110011;

  always #5 clk = ~clk;

  hazard_ctrl #(.XADDR(5), .FLUSH_CYCLES(2)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_id_valid      (id_valid),
    .i_id_rs1_addr   (rs1),
    .i_id_rs2_addr   (rs2),
    .i_id_uses_rs1   (uses_rs1),
    .i_id_uses_rs2   (uses_rs2),
    .i_id_rd_addr    (rd),
    .i_id_is_load    (is_load),
    .i_wb_load_valid (wb_valid),
    .i_wb_rd_addr    (wb_rd),
    .i_ex_redirect   (redir),
    .i_mem_req       (mem_req),
    .i_mem_ready     (mem_ready),
    .o_stall_if      (stall_if),
    .o_stall_id      (stall_id),
    .o_bubble_ex     (bubble_ex),
    .o_flush_id      (flush_id),
    .o_freeze        (freeze),
`ifdef HAZARD_PERF_EN
    .o_stall_cnt     (stall_cnt),
    .o_flush_cnt     (flush_cnt),
    .o_memwait_cnt   (memwait_cnt),
`endif
    .o_state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_valid = 0; uses_rs1 = 0; uses_rs2 = 0; is_load = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_valid = 0; wb_rd = 0;
    redir = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic id_load(input logic [4:0] r);
    id_valid = 1; is_load = 1; rd = r; uses_rs1 = 0; uses_rs2 = 0;
  endtask

  task automatic id_read(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
    id_valid = 1; is_load = 0; rd = 5'd20;
    rs1 = a1; uses_rs1 = u1; rs2 = a2; uses_rs2 = u2;
  endtask

  // Samples the control outputs mid-cycle, after inputs have settled.
  task automatic expect_out(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, freeze, stall_if, stall_id, bubble_ex, flush_id, state}, {25'd0, exp});
  endtask

  initial begin
    idle_in();
    rst = 1;
    #1;
    expect_out("reset_outputs", E_RUN);
    chk("reset_sb", dut.u_sb.pend_q, 32'd0);
    tick(); tick();
    rst = 0;
    expect_out("post_reset_run", E_RUN);
    tick();

    // Load x5 then dependent read: stall through the WB cycle, issue after.
    id_load(5'd5);          expect_out("lu_issue_load", E_RUN);   tick();
    is_load = 0; id_read(5'd5, 1, 5'd0, 0);
                            expect_out("lu_stall1", E_LDS);       tick();
    wb_valid = 1; wb_rd = 5;expect_out("lu_stall_wb", E_LDS);     tick();
    wb_valid = 0;           expect_out("lu_issue", E_RUN);        tick();

    // Load to x0 never marks a pending register.
    id_load(5'd0);          expect_out("x0_load", E_RUN);         tick();
    id_read(5'd0, 1, 5'd0, 1); expect_out("x0_read", E_RUN);      tick();
    chk("x0_sb_zero", dut.u_sb.pend_q, 32'd0);

    // rs2 path, gated by uses_rs2.
    id_load(5'd11);         expect_out("rs2_load", E_RUN);        tick();
    id_read(5'd1, 1, 5'd11, 0); expect_out("rs2_unused", E_RUN);  tick();
    id_read(5'd1, 1, 5'd11, 1); expect_out("rs2_stall", E_LDS);   tick();
    wb_valid = 1; wb_rd = 11; expect_out("rs2_stall_wb", E_LDS);  tick();
    wb_valid = 0;           expect_out("rs2_issue", E_RUN);       tick();

    // Redirect: exactly two flush cycles; the flushed load does not issue.
    id_load(5'd9); redir = 1; expect_out("redir_c0", E_FLS);      tick();
    redir = 0; idle_in();   expect_out("redir_c1", E_FLS);        tick();
                            expect_out("redir_done", E_RUN);      tick();
    id_read(5'd9, 1, 5'd0, 0); expect_out("flushed_no_sb", E_RUN); tick();
    idle_in();

    // Redirect inside FLUSH reloads the counter.
    redir = 1;              expect_out("reload_c0", E_FLS);       tick();
                            expect_out("reload_c1", E_FLS);       tick();
    redir = 0;              expect_out("reload_c2", E_FLS);       tick();
                            expect_out("reload_done", E_RUN);     tick();

    // Memory wait with redirect on its second cycle.
    mem_req = 1; mem_ready = 0; expect_out("mw_c1", E_MEMW);      tick();
    redir = 1;              expect_out("mw_c2", E_MEMW);          tick();
    redir = 0;              expect_out("mw_c3", E_MEMW);          tick();
    mem_ready = 1;          expect_out("mw_flush1", E_FLS);       tick();
    mem_req = 0;            expect_out("mw_flush2", E_FLS);       tick();
                            expect_out("mw_done", E_RUN);         tick();

    // A writeback during freeze does not clear the pending bit.
    id_load(5'd3);          expect_out("fz_load", E_RUN);         tick();
    idle_in(); mem_req = 1; wb_valid = 1; wb_rd = 3;
                            expect_out("fz_wait", E_MEMW);        tick();
    idle_in(); id_read(5'd3, 1, 5'd0, 0);
                            expect_out("fz_still_pend", E_LDS);   tick();
    wb_valid = 1; wb_rd = 3;expect_out("fz_wb", E_LDS);           tick();
    wb_valid = 0;           expect_out("fz_issue", E_RUN);        tick();

    // Same-cycle clear and set of x7: set wins.
    id_load(5'd7);          expect_out("sc_load1", E_RUN);        tick();
    wb_valid = 1; wb_rd = 7;expect_out("sc_load2", E_RUN);        tick();
    wb_valid = 0; id_read(5'd7, 1, 5'd0, 0);
                            expect_out("sc_stall", E_LDS);        tick();
    wb_valid = 1; wb_rd = 7;expect_out("sc_stall_wb", E_LDS);     tick();
    wb_valid = 0;           expect_out("sc_issue", E_RUN);        tick();

    // Asynchronous reset during FLUSH.
    idle_in(); id_load(5'd4);  expect_out("ar_load", E_RUN);      tick();
    idle_in(); redir = 1;      expect_out("ar_redir", E_FLS);     tick();
    redir = 0;
    #2;
    rst = 1;
    expect_out("ar_async_zero", E_RUN);
    chk("ar_sb_cleared", dut.u_sb.pend_q, 32'd0);
    tick();
    rst = 0;                expect_out("ar_after_run", E_RUN);    tick();
    id_read(5'd4, 1, 5'd0, 0); expect_out("ar_x4_free", E_RUN);   tick();
    idle_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
